// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe: multi-lane AES forward/inverse S-box with a valid/ready pipeline.
// The inverse table is derived from the forward table at elaboration time.
module aes_sbox_pipe #(
    parameter int LANES = 4,
    parameter bit OUT_REG = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_inv,
    output logic [8*LANES-1:0] out_data,
    output logic               busy,
    output logic [15:0]        xfer_count
);
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at the top-down byte position, i.e. bits [8*(255-x) +: 8].
    function automatic logic [2047:0] build_inv();
        logic [2047:0] t;
        t = '0;
        for (int k = 0; k < 256; k++)
            t[{~SBOX_TAB[{~k[7:0], 3'b000} +: 8], 3'b000} +: 8] = k[7:0];
        return t;
    endfunction

    localparam logic [2047:0] INV_TAB = build_inv();

    logic               s1_v, s1_inv, s1_ready, accept;
    logic [8*LANES-1:0] s1_data, sub;

    assign in_ready = s1_ready;
    assign accept   = in_valid && s1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v       <= 1'b0;
            s1_inv     <= 1'b0;
            s1_data    <= '0;
            xfer_count <= '0;
        end else begin
            if (s1_ready) s1_v <= in_valid;
            if (accept) begin
                s1_data    <= in_data;
                s1_inv     <= in_inv;
                xfer_count <= xfer_count + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] b;
        assign b = s1_data[8*i +: 8];
        assign sub[8*i +: 8] = s1_inv ? INV_TAB[{~b, 3'b000} +: 8] : SBOX_TAB[{~b, 3'b000} +: 8];
    end

    if (OUT_REG) begin : g_reg
        logic               s2_v, s2_inv;
        logic [8*LANES-1:0] s2_data;
        logic               s2_ready;
        assign s2_ready = !s2_v || out_ready;
        assign s1_ready = !s1_v || s2_ready;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_v    <= 1'b0;
                s2_inv  <= 1'b0;
                s2_data <= '0;
            end else if (s2_ready) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_data <= sub;
                    s2_inv  <= s1_inv;
                end
            end
        end
        assign out_valid = s2_v;
        assign out_data  = s2_data;
        assign out_inv   = s2_inv;
        assign busy      = s1_v || s2_v;
    end else begin : g_comb
        assign s1_ready  = !s1_v || out_ready;
        assign out_valid = s1_v;
        assign out_data  = s1_v ? sub : '0;
        assign out_inv   = s1_v && s1_inv;
        assign busy      = s1_v;
    end
endmodule
